// File: rtl/cordic_pkg.sv
// Shared constants and state encoding for the CORDIC vectoring unit.
// Used by the controller, datapath and arctan ROM wrapper.
package cordic_pkg;

  localparam int DEF_ADDRESS_LENGTH = 4;
  localparam int DEF_NUM_ITER       = 14;
  localparam int DEF_WORD_LENGTH    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_iter_counter.sv
// Iteration index for the vectoring controller.
// Clears on load, steps per micro-rotation, flags the final index.
module cordic_iter_counter #(
  parameter int AW   = 4,
  parameter int LAST = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt,
  output logic          last
);

  logic [AW-1:0] cnt_q;
  logic [AW-1:0] cnt_d;

  assign last = (cnt_q == AW'(LAST));
  assign cnt  = cnt_q;

  // Terminal index folds back to zero so the count never wraps past LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cordic_vectoring_ctrl.sv
// Sequencer for the CORDIC vectoring datapath: load, NUM_ITER
// micro-rotations, then hold done until the consumer acks.
module cordic_vectoring_ctrl
  import cordic_pkg::*;
#(
  parameter int ADDRESS_LENGTH = DEF_ADDRESS_LENGTH,
  parameter int NUM_ITER       = DEF_NUM_ITER
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      y_sign,
  input  logic                      ack,
  output logic                      ready,
  output logic                      ld_en,
  output logic                      it_en,
  output logic                      dir,
  output logic [ADDRESS_LENGTH-1:0] rom_addr,
  output logic                      done
);

  if (NUM_ITER < 1 || NUM_ITER > (1 << ADDRESS_LENGTH)) begin : g_bad_iter
    $error("NUM_ITER out of range for ADDRESS_LENGTH");
  end

  state_e                    state_q;
  state_e                    state_d;
  logic [ADDRESS_LENGTH-1:0] iter;
  logic                      iter_last;

  cordic_iter_counter #(
    .AW   (ADDRESS_LENGTH),
    .LAST (NUM_ITER - 1)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .clr  (ld_en),
    .inc  (it_en),
    .cnt  (iter),
    .last (iter_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (iter_last) state_d = DONE;
      DONE:    if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore decode; only dir looks at an input, and only while rotating.
  always_comb begin
    ready    = 1'b0;
    ld_en    = 1'b0;
    it_en    = 1'b0;
    dir      = 1'b0;
    rom_addr = '0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: ready = 1'b1;
      LOAD: ld_en = 1'b1;
      ITER: begin
        it_en    = 1'b1;
        dir      = ~y_sign;
        rom_addr = iter;
      end
      DONE:    done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_ctrl.sv
// Bench for cordic_vectoring_ctrl: vector table with a per-rotation
// scoreboard, handshake/reset corners, N=1/N=16 builds and a datapath model.
module tb_cordic_vectoring_ctrl;
  import cordic_pkg::*;

  localparam int N  = DEF_NUM_ITER;
  localparam int AW = DEF_ADDRESS_LENGTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start0, ack0, y_sign0;
  logic ready0, ld_en0, it_en0, dir0, done0;
  logic [AW-1:0] rom0;

  logic start1, ack1;
  logic ready1, ld_en1, it_en1, dir1, done1;
  logic [AW-1:0] rom1;

  logic start16, ack16;
  logic ready16, ld_en16, it_en16, dir16, done16;
  logic [AW-1:0] rom16;

  cordic_vectoring_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start0), .y_sign(y_sign0), .ack(ack0),
    .ready(ready0), .ld_en(ld_en0), .it_en(it_en0), .dir(dir0),
    .rom_addr(rom0), .done(done0)
  );

  cordic_vectoring_ctrl #(.NUM_ITER(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_sign(1'b0), .ack(ack1),
    .ready(ready1), .ld_en(ld_en1), .it_en(it_en1), .dir(dir1),
    .rom_addr(rom1), .done(done1)
  );

  cordic_vectoring_ctrl #(.NUM_ITER(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .y_sign(1'b1), .ack(ack16),
    .ready(ready16), .ld_en(ld_en16), .it_en(it_en16), .dir(dir16),
    .rom_addr(rom16), .done(done16)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          dir;
  } exp_t;

  exp_t sb[$];
  logic [15:0] pat_cur = '0;
  logic        e2e = 1'b0;
  int          ld_cnt = 0;

  // Datapath model: 20-bit signed x/y/z, angle unit pi = 2**15.
  logic signed [19:0] xm, ym, zm;

  function automatic logic signed [19:0] atan_rom(input logic [AW-1:0] i);
    case (i)
      4'd0:  return 20'sd8192;
      4'd1:  return 20'sd4836;
      4'd2:  return 20'sd2555;
      4'd3:  return 20'sd1297;
      4'd4:  return 20'sd651;
      4'd5:  return 20'sd326;
      4'd6:  return 20'sd163;
      4'd7:  return 20'sd81;
      4'd8:  return 20'sd41;
      4'd9:  return 20'sd20;
      4'd10: return 20'sd10;
      4'd11: return 20'sd5;
      4'd12: return 20'sd3;
      4'd13: return 20'sd1;
      default: return 20'sd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ld_en0) begin
      xm <= 20'sd8192;
      ym <= 20'sd8192;
      zm <= 20'sd0;
    end else if (it_en0) begin
      if (dir0) begin
        ym <= ym - (xm >>> rom0);
        xm <= xm + (ym >>> rom0);
        zm <= zm + atan_rom(rom0);
      end else begin
        ym <= ym + (xm >>> rom0);
        xm <= xm - (ym >>> rom0);
        zm <= zm - atan_rom(rom0);
      end
    end
  end

  assign y_sign0 = e2e ? ym[19] : pat_cur[rom0];

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst !== 1'b1) begin
      if (ld_en0) ld_cnt++;
      if (it_en0 && !e2e) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rom_addr", 32'(rom0), 32'(e.addr));
          chk("dir_iter", 32'(dir0), 32'(e.dir));
        end
      end else if (!it_en0) begin
        chk("dir_idle", 32'(dir0), 32'd0);
      end
    end
  end

  typedef struct {
    logic [15:0] pat;
    logic [15:0] exp_dir;
    int          exp_done_k;
    int          ack_delay;
    bit          hold_start;
    bit          start_w_ack;
    bit          ack_noise;
  } vec_t;

  vec_t tbl[4];

  task automatic run_op(input vec_t v);
    exp_t e;
    @(negedge clk);
    chk("ready_before", 32'(ready0), 32'd1);
    pat_cur = v.pat;
    ld_cnt  = 0;
    for (int i = 0; i < N; i++) begin
      e.addr = AW'(i);
      e.dir  = v.exp_dir[i];
      sb.push_back(e);
    end
    start0 = 1'b1;
    for (int k = 1; k <= v.exp_done_k; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("ld_en_k1", 32'(ld_en0), 32'd1);
        chk("ready_k1", 32'(ready0), 32'd0);
        start0 = v.hold_start;
        ack0   = v.ack_noise;
      end else if (k == v.exp_done_k) begin
        chk("done_k", 32'(done0), 32'd1);
        chk("it_en_off", 32'(it_en0), 32'd0);
      end else begin
        chk("it_en_on", 32'(it_en0), 32'd1);
        if (k == v.exp_done_k - 1) ack0 = 1'b0;
      end
    end
    repeat (v.ack_delay) begin
      @(negedge clk);
      chk("done_held", 32'(done0), 32'd1);
    end
    ack0   = 1'b1;
    start0 = v.hold_start | v.start_w_ack;
    @(negedge clk);
    chk("done_cleared", 32'(done0), 32'd0);
    chk("ready_after", 32'(ready0), 32'd1);
    ack0   = 1'b0;
    start0 = 1'b0;
    @(negedge clk);
    chk("no_reload", 32'(ld_en0), 32'd0);
    chk("ld_count", 32'(ld_cnt), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h2AAA, 16'h1555, N + 2, 0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h3FFF, N + 2, 1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{16'h3FFF, 16'h0000, N + 2, 5, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h0F0C, 16'h30F3, N + 2, 2, 1'b0, 1'b1, 1'b0};

    start0 = 0; ack0 = 0; start1 = 0; ack1 = 0; start16 = 0; ack16 = 0;
    rst = 1'b1;
    #12;
    chk("rst_ready", 32'(ready0), 32'd1);
    chk("rst_outs", 32'({ld_en0, it_en0, dir0, done0, rom0}), 32'd0);
    chk("rst_ready16", 32'(ready16), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i]);

    // Reset in the middle of the rotations.
    begin : mid_reset
      exp_t e;
      bit hit = 1'b0;
      pat_cur = '0;
      for (int i = 0; i < N; i++) begin
        e.addr = AW'(i);
        e.dir  = 1'b1;
        sb.push_back(e);
      end
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
        @(negedge clk);
        if (it_en0 && rom0 == AW'(5)) hit = 1'b1;
      end
      chk("reach_iter5", 32'(hit), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_ready", 32'(ready0), 32'd1);
      chk("midrst_it_en", 32'(it_en0), 32'd0);
      chk("midrst_rom", 32'(rom0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
    end

    // Single-iteration build.
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("n1_ld", 32'(ld_en1), 32'd1);
    @(negedge clk);
    chk("n1_it", 32'({it_en1, rom1}), 32'h10);
    @(negedge clk);
    chk("n1_it_off", 32'(it_en1), 32'd0);
    chk("n1_done", 32'(done1), 32'd1);
    ack1 = 1'b1;
    @(negedge clk);
    ack1 = 1'b0;
    chk("n1_ready", 32'(ready1), 32'd1);

    // Full 16-entry address space, no wrap.
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    chk("n16_ld", 32'(ld_en16), 32'd1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("n16_it", 32'({it_en16, rom16}), 32'({1'b1, AW'(i)}));
      chk("n16_dir", 32'(dir16), 32'd0);
    end
    @(negedge clk);
    chk("n16_done", 32'({done16, it_en16, rom16}), 32'h20);
    ack16 = 1'b1;
    @(negedge clk);
    ack16 = 1'b0;
    chk("n16_ready", 32'(ready16), 32'd1);

    // End-to-end against the datapath model: 45 degrees.
    begin : e2e_run
      bit got = 1'b0;
      e2e = 1'b1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (done0) got = 1'b1;
      end
      chk("e2e_done", 32'(got), 32'd1);
      chk("e2e_z", 32'(zm >= 20'sd8190 && zm <= 20'sd8194), 32'd1);
      chk("e2e_x", 32'(xm >= 20'sd19070 && xm <= 20'sd19086), 32'd1);
      ack0 = 1'b1;
      @(negedge clk);
      ack0 = 1'b0;
      e2e  = 1'b0;
      chk("e2e_ready", 32'(ready0), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
